// File: rtl/detector_item_nao_reciclavel_if.sv
// Sensor inputs and count/status outputs of the item detector, bundled so the
// sorting-line top level can pass them around as a single port.
interface detector_item_nao_reciclavel_if;
    logic sensor_presence;
    logic sensor_material;
    logic count_nr;
    logic count_r;
    logic busy;
    logic fault;

    // Driver side: the sensors (or a bench) drive the inputs and observe the results.
    modport master (
        output sensor_presence,
        output sensor_material,
        input  count_nr,
        input  count_r,
        input  busy,
        input  fault
    );

    // Detector side.
    modport slave (
        input  sensor_presence,
        input  sensor_material,
        output count_nr,
        output count_r,
        output busy,
        output fault
    );
endinterface

// File: rtl/detector_item_nao_reciclavel.sv
// Item detector for the sorting line: debounces the presence sensor, classifies
// each item by the material sensor at acceptance time and emits exactly one
// single-cycle count pulse per physical item (count_nr / count_r). An item that
// stays in front of the sensor for too long raises fault until the sensor has
// been clear for a full debounce window.
module detector_item_nao_reciclavel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 16
) (
    input logic                            clock,
    input logic                            clear,
    detector_item_nao_reciclavel_if.slave  bus
);

    localparam int MAX_COUNT = (DEBOUNCE_CYCLES > STUCK_CYCLES) ? DEBOUNCE_CYCLES : STUCK_CYCLES;
    localparam int CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] DEB_LIMIT   = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] STUCK_LIMIT = CW'(STUCK_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        WAIT_CLEAR,
        FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;   // consecutive high samples while debouncing
    logic [CW-1:0] lo_q,  lo_d;    // consecutive low samples after the pulse / in FAULT
    logic [CW-1:0] hi_q,  hi_d;    // high samples accumulated after the pulse

    logic count_nr_q;
    logic count_r_q;
    logic busy_q;
    logic fault_q;

    // Saturating increment: counters stop at their limit instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value,
                                              input logic [CW-1:0] limit);
        return (value < limit) ? value + 1'b1 : value;
    endfunction

    // Next-state and counter update logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        lo_d    = lo_q;
        hi_d    = hi_q;

        case (state_q)
            IDLE: begin
                if (bus.sensor_presence) begin
                    state_d = DEBOUNCE;
                    cnt_d   = CW'(1);
                end
            end

            DEBOUNCE: begin
                if (bus.sensor_presence) begin
                    cnt_d = sat_inc(cnt_q, DEB_LIMIT);
                    if (cnt_d == DEB_LIMIT) begin
                        state_d = EMIT;
                        cnt_d   = '0;
                    end
                end else begin
                    // Glitch shorter than the debounce window: drop it silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            EMIT: begin
                // The pulse is already on the output; the sample taken here is ignored.
                state_d = WAIT_CLEAR;
                lo_d    = '0;
                hi_d    = '0;
            end

            WAIT_CLEAR: begin
                if (bus.sensor_presence) begin
                    lo_d = '0;
                    hi_d = sat_inc(hi_q, STUCK_LIMIT);
                end else begin
                    lo_d = sat_inc(lo_q, DEB_LIMIT);
                end
                // A stuck item takes priority over the item leaving.
                if (hi_d == STUCK_LIMIT) begin
                    state_d = FAULT;
                    lo_d    = '0;
                    hi_d    = '0;
                end else if (lo_d == DEB_LIMIT) begin
                    state_d = IDLE;
                    lo_d    = '0;
                    hi_d    = '0;
                end
            end

            FAULT: begin
                lo_d = bus.sensor_presence ? '0 : sat_inc(lo_q, DEB_LIMIT);
                if (lo_d == DEB_LIMIT) begin
                    state_d = IDLE;
                    lo_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                lo_d    = '0;
                hi_d    = '0;
            end
        endcase
    end

    // State and counter registers with synchronous active-low clear.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    // Registered outputs decoded from the next state; the material bit is
    // captured on the same edge that accepts the item.
    always_ff @(posedge clock) begin
        if (!clear) begin
            count_nr_q <= 1'b0;
            count_r_q  <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            count_nr_q <= (state_d == EMIT) && !bus.sensor_material;
            count_r_q  <= (state_d == EMIT) &&  bus.sensor_material;
            busy_q     <= (state_d != IDLE);
            fault_q    <= (state_d == FAULT);
        end
    end

    assign bus.count_nr = count_nr_q;
    assign bus.count_r  = count_r_q;
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;

endmodule
